// File: rtl/som_ram_arbiter.sv
// som_ram_arbiter: round-robin arbiter/sequencer for the shared SOM RAM with a zero-fill clear engine.
// Define ARB_LOCK_EN to add a per-requester lock port that pins the priority pointer during bursts.
module som_ram_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 24,
  parameter int MEM_DEPTH = 61440
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        err,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  input  logic                      clear_start,
  output logic                      clear_done,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ram_A,
  output logic                      ram_WE,
  output logic                      ram_OE,
  output logic [DATA_W-1:0]         ram_D,
  input  logic [DATA_W-1:0]         ram_Q
);
  typedef enum logic [1:0] {RUN, CLEAR, FIN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  state_t state, state_nx;
  logic [1:0] ptr, ptr_nx, sel;
  logic hit, run, sel_ok, keep;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_REQ-1:0] rd_pend;
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!hit && req[(int'(ptr) + k) % NUM_REQ]) begin
        hit = 1'b1;
        sel = 2'((int'(ptr) + k) % NUM_REQ);
      end
    sel_addr = addr[sel*ADDR_W +: ADDR_W];
    sel_data = wdata[sel*DATA_W +: DATA_W];
    sel_ok   = sel_addr < ADDR_W'(MEM_DEPTH);
    run      = rst_n && state == RUN && !clear_start && hit;
    gnt      = run ? NUM_REQ'(1) << sel : '0;
    err      = sel_ok ? '0 : gnt;
`ifdef ARB_LOCK_EN
    keep     = lock[sel];
`else
    keep     = 1'b0;
`endif
    ptr_nx   = !run ? ptr : keep ? sel : sel == 2'(NUM_REQ - 1) ? 2'd0 : sel + 2'd1;
    state_nx = state == RUN   ? (clear_start ? CLEAR : RUN) :
               state == CLEAR ? (ram_A == LAST ? FIN : CLEAR) : RUN;
    busy       = state != RUN;
    clear_done = state == FIN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= RUN;
      ptr     <= '0;
      rd_pend <= '0;
      rvalid  <= '0;
      rdata   <= '0;
      ram_A   <= '0;
      ram_WE  <= 1'b0;
      ram_OE  <= 1'b0;
      ram_D   <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      rd_pend <= (run && sel_ok && !we[sel]) ? gnt : '0;
      rvalid  <= rd_pend;
      if (|rd_pend) rdata <= ram_Q;
      // clear engine owns the RAM pins from the start cycle through the last address
      if (state == RUN && clear_start) begin
        ram_A  <= '0;
        ram_WE <= 1'b1;
        ram_OE <= 1'b0;
        ram_D  <= '0;
      end else if (state == CLEAR) begin
        ram_A  <= ram_A + ADDR_W'(ram_A != LAST);
        ram_WE <= ram_A != LAST;
        ram_OE <= 1'b0;
        ram_D  <= '0;
      end else begin
        ram_A  <= run ? sel_addr : ram_A;
        ram_WE <= run && sel_ok && we[sel];
        ram_OE <= run && sel_ok && !we[sel];
        ram_D  <= run ? sel_data : ram_D;
      end
    end
endmodule

// File: tb/tb_som_ram_arbiter.sv
// tb_som_ram_arbiter: randomized + directed bench for som_ram_arbiter against a transaction-level model.
module tb_som_ram_arbiter;
  localparam int N = 3, AW = 18, DW = 24, DEPTH = 61440;
  logic clk = 0, rst_n = 0, clear_start = 0;
  logic [N-1:0] req = '0, we = '0, lock = '0, gnt, err, rvalid;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [DW-1:0] rdata, ram_D, ram_Q = '0;
  logic clear_done, busy, ram_WE, ram_OE;
  logic [AW-1:0] ram_A;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] shadow [0:DEPTH-1];
  typedef struct {int due; int idx; logic [DW-1:0] d;} rv_t;
  rv_t rvq[$];
  int m_ptr = 0, m_mode = 0, m_k = 0, cyc = 0, p_a = 0;
  bit p_we = 0, p_oe = 0, g_err;
  logic [DW-1:0] p_d = '0;

  som_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata), .clear_start(clear_start),
    .clear_done(clear_done), .busy(busy), .ram_A(ram_A), .ram_WE(ram_WE), .ram_OE(ram_OE),
    .ram_D(ram_D), .ram_Q(ram_Q));

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_WE) mem[ram_A] <= ram_D;
  always @(negedge clk) ram_Q <= ram_OE ? mem[ram_A] : DW'($urandom);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pointer as an integer, RAM contents as a shadow array, reads as a due-time queue.
  always @(negedge clk) begin
    int g, a;
    logic [N-1:0] e_gnt, e_err, e_rv;
    logic [DW-1:0] e_rd;
    bit n_we, n_oe;
    if (!rst_n) begin
      m_ptr = 0; m_mode = 0; m_k = 0; p_we = 0; p_oe = 0;
      rvq.delete();
    end else begin
      cyc++;
      g = -1; a = 0; e_gnt = '0; e_err = '0; e_rv = '0; e_rd = '0; n_we = 0; n_oe = 0;
      if (m_mode == 0 && !clear_start)
        for (int k = 0; k < N; k++) if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        a = int'(addr[g*AW +: AW]);
        e_gnt[g] = 1'b1;
        e_err[g] = a >= DEPTH;
      end
      if (rvq.size() > 0 && rvq[0].due == cyc) begin
        e_rv[rvq[0].idx] = 1'b1;
        e_rd = rvq[0].d;
        rvq.delete(0);
      end
      chk("gnt", gnt, e_gnt);
      chk("err", err, e_err);
      chk("rvalid", rvalid, e_rv);
      if (e_rv != 0) chk("rdata", rdata, e_rd);
      chk("busy", busy, m_mode != 0);
      chk("clear_done", clear_done, m_mode == 2);
      if (m_mode == 1) begin
        chk("clr_we", {ram_WE, ram_OE}, 2'b10);
        chk("clr_a", ram_A, m_k);
        chk("clr_d", ram_D, 0);
      end else begin
        chk("ram_we", ram_WE, p_we);
        chk("ram_oe", ram_OE, p_oe);
        if (p_we || p_oe) chk("ram_a", ram_A, p_a);
        if (p_we) chk("ram_d", ram_D, p_d);
      end
      if (m_mode == 0) begin
        if (clear_start) begin
          m_mode = 1; m_k = 0;
        end else if (g >= 0) begin
          if (a < DEPTH) begin
            p_a = a;
            p_d = wdata[g*DW +: DW];
            if (we[g]) begin shadow[a] = p_d; n_we = 1; end
            else begin rvq.push_back('{cyc + 2, g, shadow[a]}); n_oe = 1; end
          end
          m_ptr = lock[g] ? g : (g + 1) % N;
        end
      end else if (m_mode == 1) begin
        shadow[m_k] = '0;
        if (m_k == DEPTH - 1) m_mode = 2; else m_k++;
      end else m_mode = 0;
      p_we = n_we; p_oe = n_oe;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic access(input int i, input bit w, input int a, input logic [DW-1:0] d);
    bit got = 0;
    req[i] = 1; we[i] = w; addr[i*AW +: AW] = AW'(a); wdata[i*DW +: DW] = d;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = gnt[i];
      g_err = err[i];
      if (!got) tick();
    end
    chk("gnt_wait", got, 1);
    tick();
    req[i] = 0;
  endtask

  task automatic rd_chk(input string nm, input int i, input int a, input logic [DW-1:0] exp);
    access(i, 0, a, '0);
    @(negedge clk);
    chk({nm, "_early"}, rvalid[i], 0);
    tick();
    @(negedge clk);
    chk({nm, "_rv"}, rvalid[i], 1);
    chk({nm, "_data"}, rdata, exp);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 0; req = '0; clear_start = 0; lock = '0;
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    int busy_n;
    bit done_seen, found;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(i * 37 + 5);
      shadow[i] = mem[i];
    end
    tick(); tick();
    chk("rst_a", {gnt, err, rvalid, clear_done, busy, ram_WE, ram_OE}, 0);
    chk("rst_b", {rdata, ram_A, ram_D}, 0);
    rst_n = 1;
    access(0, 1, 5, 24'hABCDEF);
    rd_chk("wr_rd", 0, 5, 24'hABCDEF);
    do_reset();
    req = '1; we = '0; addr = {18'd30, 18'd20, 18'd10};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 6) chk("cont_gnt", gnt, 3'b001 << (c % 3));
      if (c >= 2) chk("cont_rv", rvalid, 3'b001 << ((c - 2) % 3));
      tick();
      if (c == 5) req = '0;
    end
    access(1, 0, 61440, '0);
    chk("oor_err", g_err, 1);
    @(negedge clk);
    chk("oor_oe", ram_OE, 0);
    tick();
    @(negedge clk);
    chk("oor_norv", rvalid[1], 0);
    access(1, 0, 61439, '0);
    chk("edge_err", g_err, 0);
    @(negedge clk);
    chk("edge_oe", ram_OE, 1);
    tick();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i] = 1'($urandom);
        we[i] = 1'($urandom);
        addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'(61436 + $urandom_range(0, 7)) : AW'($urandom_range(0, 31));
        wdata[i*DW +: DW] = DW'($urandom);
`ifdef ARB_LOCK_EN
        lock[i] = $urandom_range(0, 3) == 0;
`endif
      end
      tick();
    end
    req = '0; lock = '0;
    tick(); tick(); tick();
`ifdef ARB_LOCK_EN
    do_reset();
    req = 3'b011; we = '0; lock = 3'b001; addr = {18'd3, 18'd2, 18'd1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("lock_gnt", gnt, c < 5 ? 3'b001 : 3'b010);
      tick();
      if (c == 3) lock = '0;
    end
    req = '0;
    tick(); tick(); tick();
`endif
    access(0, 1, 0, 24'h123456);
    access(0, 1, 61439, 24'h123456);
    access(2, 0, 3, '0);
    clear_start = 1; req[1] = 1; we[1] = 0; addr[AW +: AW] = 18'd7;
    @(negedge clk);
    chk("clr_nognt", gnt, 0);
    tick();
    clear_start = 0;
    busy_n = 0; done_seen = 0;
    for (int t = 0; t < 70000 && !done_seen; t++) begin
      @(negedge clk);
      if (busy) busy_n++;
      done_seen = clear_done;
      tick();
      clear_start = t == 1000;
    end
    clear_start = 0;
    chk("clr_done", done_seen, 1);
    chk("clr_busy_len", busy_n, 61441);
    access(1, 0, 7, '0);
    rd_chk("clr_rd0", 0, 0, '0);
    rd_chk("clr_rdlast", 2, 61439, '0);
    access(0, 1, 99, 24'hCCCCCC);
    access(0, 1, 100, 24'hAAAAAA);
    access(0, 1, 200, 24'hBBBBBB);
    clear_start = 1;
    tick();
    clear_start = 0;
    found = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      found = busy && ram_A == 18'd100;
      if (!found) tick();
    end
    chk("rstclr_reach", found, 1);
    rst_n = 0;
    #1;
    chk("rstclr_a", {gnt, err, rvalid, clear_done, busy, ram_WE, ram_OE}, 0);
    chk("rstclr_b", {rdata, ram_A, ram_D}, 0);
    tick(); tick();
    rst_n = 1;
    tick(); tick();
    rd_chk("rstclr_99", 0, 99, '0);
    rd_chk("rstclr_100", 1, 100, 24'hAAAAAA);
    rd_chk("rstclr_200", 2, 200, 24'hBBBBBB);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/som_ram_arbiter.md
Name: som_ram_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 24-bit × 61440-word SOM pixel/weight RAM.
- Serves NUM_REQ requesters: image loader, weight-update engine, result dumper.
- Owns all RAM control pins and includes a clear engine that zero-fills the RAM on command.
- Sits between the SOM datapath engines and the RAM instance in the top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- ADDR_W, 18, RAM address width.
- DATA_W, 24, RAM data width.
- MEM_DEPTH, 61440, valid word count; addresses at or above this are illegal.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request; held until gnt.
- we  in  NUM_REQ  per-requester write (1) or read (0).
- addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot acceptance pulse.
- err  out  NUM_REQ  out-of-range pulse, coincident with gnt.
- rvalid  out  NUM_REQ  one-hot read-data-valid pulse.
- rdata  out  DATA_W  read data, valid while any rvalid is high.
- clear_start  in  1  pulse: zero-fill the whole RAM.
- clear_done  out  1  pulse when zero-fill completes.
- busy  out  1  high while the clear engine runs.
- ram_A  out  ADDR_W  RAM address.
- ram_WE  out  1  RAM write enable.
- ram_OE  out  1  RAM read enable.
- ram_D  out  DATA_W  RAM write data.
- ram_Q  in  DATA_W  RAM read data; valid after the falling edge of the cycle ram_A is driven.

Behaviour:
- Reset values: gnt, err, rvalid, rdata, clear_done, busy, ram_A, ram_WE, ram_OE, ram_D all 0. Priority pointer 0. FSM in RUN.
- FSM states:
  - RUN: arbitration active.
  - CLEAR: zero-fill in progress.
  - FIN: one cycle; pulses clear_done, then returns to RUN.
- RUN arbitration:
  - Each cycle, pick the first i with req[i]=1, searching from the pointer upward with wrap.
  - Assert gnt[i] that cycle (combinational from req and pointer).
  - Register ram_A/ram_WE/ram_OE/ram_D for the next cycle. Pointer becomes (i+1) mod NUM_REQ.
  - No req: ram_WE=0, ram_OE=0, pointer unchanged.
  - Throughput is one access per cycle.
- Write timing: gnt in cycle N; ram_WE=1 and ram_D driven in N+1; RAM commits at the end of N+1.
- Read timing: gnt in cycle N; ram_OE=1 and ram_A driven in N+1. ram_Q is captured at the end of N+1. rvalid[i]=1 and rdata in N+2, so latency is 2 cycles from gnt.
  - Back-to-back reads give back-to-back rvalid pulses.
- Out of range (addr >= MEM_DEPTH):
  - gnt[i] and err[i] pulse together.
  - The next cycle has ram_WE=0 and ram_OE=0.
  - No rvalid is produced; the pointer still advances.
- Read-after-write to the same address, granted in consecutive cycles, returns the new data; this follows from the RAM's write-before-latch timing.
- ram_OE=0 in every cycle without a read; ram_Q is ignored then.
- clear_start in RUN:
  - No gnt in the start cycle.
  - Enter CLEAR next cycle. busy=1 from the cycle after clear_start until FIN exits.
  - CLEAR drives ram_WE=1, ram_D=0, ram_A=0,1,...,MEM_DEPTH-1, one per cycle.
  - After the last address, go to FIN: clear_done=1 for one cycle, busy=0 from the following cycle.
- clear_start while busy is ignored.
- A read granted before clear_start still returns its rvalid normally.
- In CLEAR/FIN, gnt stays 0; requests wait with req held.
- Simultaneous clear_start and req in RUN: the clear wins and no gnt is issued.
- Reset mid-operation: everything returns to reset values immediately. Pending rvalid is dropped. An active clear is aborted and clear_done is not pulsed.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro defined:
  - Extra input port lock, NUM_REQ bits.
  - If the granted requester i has lock[i]=1, the pointer stays at i, so i keeps top priority while it keeps req and lock high (burst read-modify-write).
  - The pointer advances normally on the first grant with lock[i]=0.
  - Locking does not block clear_start.
- Without the macro: no lock port; pure round-robin.

Test Plan:
- Write then read, requester 0: req0 write addr 5 data 24'hABCDEF; then read addr 5 → rvalid[0] exactly 2 cycles after read gnt, rdata=24'hABCDEF.
- Contention, all 3 requesters holding reads for 6 cycles from reset → gnt order 0,1,2,0,1,2; rvalid follows the same order with 2-cycle lag.
- Out of range: req1 read addr 61440 → gnt[1]=err[1]=1 same cycle; ram_OE=0 next cycle; no rvalid[1]. Addr 61439 is accepted normally.
- Clear: write 24'h123456 at addr 0 and 61439, pulse clear_start → busy high for 61441 cycles, clear_done after 61440 writes; reads of both addresses return 0.
- Reset mid-clear: assert rst_n=0 at clear address 100 → all outputs 0 immediately, no clear_done; after release, addresses ≥100 keep old data.
- ARB_LOCK_EN: req0 with lock0=1 and req1 both held 4 cycles → gnt[0] all 4 cycles; lock0 drops → next gnt goes to 1.
